// File: rtl/rv32i_types.sv
// Shared RV32I execute types: ALU/compare encodings, control word, operand bundle and branch modes.
// Pure declarations with no latency and no flow control.
package rv32i_types;

    localparam int ALU_PIPE_MAX_STAGES = 4;

    typedef enum logic [2:0] {
        alu_add = 3'b000,
        alu_sll = 3'b001,
        alu_sra = 3'b010,
        alu_sub = 3'b011,
        alu_xor = 3'b100,
        alu_srl = 3'b101,
        alu_or  = 3'b110,
        alu_and = 3'b111
    } alu_ops_t;

    // 3'b010 and 3'b011 are left undefined and compare false.
    typedef enum logic [2:0] {
        cmp_beq  = 3'b000,
        cmp_bne  = 3'b001,
        cmp_blt  = 3'b100,
        cmp_bge  = 3'b101,
        cmp_bltu = 3'b110,
        cmp_bgeu = 3'b111
    } cmp_ops_t;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_COND = 2'd1,
        BR_JAL  = 2'd2,
        BR_JALR = 2'd3
    } br_mode_t;

    typedef struct packed {
        alu_ops_t alu_op;
        cmp_ops_t cmp_op;
        logic     alu_m1_sel;
        logic     alu_m2_sel;
        logic     alu_cmp_sel;
    } ctrl_word_t;

    typedef struct packed {
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] rd_data;
    } ooo_instr_t;

    typedef struct packed {
        ooo_instr_t  instr;
        logic        br_en;
        logic [31:0] target;
    } stage_t;

endpackage

// File: rtl/alu_cmp_core.sv
// Combinational ALU, comparator and branch resolver shared by every ALU port.
// Zero latency, no state, no flow control.
module alu_cmp_core
    import rv32i_types::*;
(
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    input  ctrl_word_t  ctrl,
    input  br_mode_t    br_mode,
    output logic [31:0] rd_data,
    output logic        br_en,
    output logic [31:0] target
);

    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] aluout;
    logic [31:0] pc_plus4;
    logic        cmp;

    always_comb begin
        a        = ctrl.alu_m1_sel ? pc : rs1_data;
        b        = ctrl.alu_m2_sel ? imm : rs2_data;
        pc_plus4 = pc + 32'd4;

        aluout = '0;
        case (ctrl.alu_op)
            alu_add: aluout = a + b;
            alu_sub: aluout = a - b;
            alu_sll: aluout = a << b[4:0];
            alu_srl: aluout = a >> b[4:0];
            alu_sra: aluout = $unsigned($signed(a) >>> b[4:0]);
            alu_xor: aluout = a ^ b;
            alu_or:  aluout = a | b;
            alu_and: aluout = a & b;
            default: aluout = '0;
        endcase

        // The comparator always uses rs1, never the pc-muxed operand.
        cmp = 1'b0;
        case (ctrl.cmp_op)
            cmp_beq:  cmp = (rs1_data == b);
            cmp_bne:  cmp = (rs1_data != b);
            cmp_blt:  cmp = ($signed(rs1_data) <  $signed(b));
            cmp_bge:  cmp = ($signed(rs1_data) >= $signed(b));
            cmp_bltu: cmp = (rs1_data <  b);
            cmp_bgeu: cmp = (rs1_data >= b);
            default:  cmp = 1'b0;
        endcase

        rd_data = ctrl.alu_cmp_sel ? {31'b0, cmp} : aluout;
        br_en   = 1'b0;
        target  = pc_plus4;
        case (br_mode)
            BR_COND: begin
                br_en  = cmp;
                target = cmp ? (pc + imm) : pc_plus4;
            end
            BR_JAL: begin
                rd_data = pc_plus4;
                br_en   = 1'b1;
                target  = pc + imm;
            end
            BR_JALR: begin
                rd_data = pc_plus4;
                br_en   = 1'b1;
                target  = (rs1_data + imm) & ~32'h1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_cmp_pipe.sv
// Pipelined ALU/compare/branch execute unit; result appears STAGES cycles after accept.
// Valid/ready per stage with no bubbles; in_ready follows out_ready combinationally through full stages.
module alu_cmp_pipe
    import rv32i_types::*;
#(
    parameter int STAGES  = 1,
    parameter int STALL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  ooo_instr_t         in_instr,
    input  ctrl_word_t         in_ctrl,
    input  br_mode_t           in_br_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output ooo_instr_t         out_instr,
    output logic               out_br_en,
    output logic [31:0]        out_br_target,
    output logic [STALL_W-1:0] stall_cnt
);

    stage_t            stage_q [STAGES];
    stage_t            stage_d;
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] load;
    logic [STAGES:0]   room;
    logic              accept;
    logic [31:0]       core_rd;
    logic              core_br_en;
    logic [31:0]       core_target;

    alu_cmp_core u_core (
        .rs1_data (in_instr.rs1_data),
        .rs2_data (in_instr.rs2_data),
        .pc       (in_instr.pc),
        .imm      (in_instr.imm),
        .ctrl     (in_ctrl),
        .br_mode  (in_br_mode),
        .rd_data  (core_rd),
        .br_en    (core_br_en),
        .target   (core_target)
    );

    always_comb begin
        stage_d               = '0;
        stage_d.instr         = in_instr;
        stage_d.instr.rd_data = core_rd;
        stage_d.br_en         = core_br_en;
        stage_d.target        = core_target;
    end

    // room[k]: stage k can take a new payload this cycle; resolved from the output backwards.
    always_comb begin
        room         = '0;
        adv          = '0;
        room[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv[k]  = valid_q[k] && room[k+1];
            room[k] = !valid_q[k] || adv[k];
        end
    end

    assign in_ready  = !rst && !flush && room[0];
    assign accept    = in_valid && in_ready;
    assign out_valid = valid_q[STAGES-1] && !flush;

    always_comb begin
        load    = '0;
        load[0] = accept;
        for (int k = 1; k < STAGES; k++) begin
            load[k] = adv[k-1];
        end
        valid_d = '0;
        for (int k = 0; k < STAGES; k++) begin
            valid_d[k] = load[k] || (valid_q[k] && !adv[k]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (load[0]) begin
            stage_q[0] <= stage_d;
        end
        for (int k = 1; k < STAGES; k++) begin
            if (load[k]) begin
                stage_q[k] <= stage_q[k-1];
            end
        end
    end

    assign out_instr     = stage_q[STAGES-1].instr;
    assign out_br_en     = stage_q[STAGES-1].br_en;
    assign out_br_target = stage_q[STAGES-1].target;

    // Survives flush so backpressure statistics span squashes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {STALL_W{1'b1}})) begin
            stall_cnt <= stall_cnt + STALL_W'(1);
        end
    end

endmodule

// File: doc/alu_cmp_pipe.md
# alu_cmp_pipe

Parametrised, pipelined integer execute unit for the out-of-order core. It sits between the ALU reservation station and the CDB arbiter and performs the same ALU/compare operations as the single-cycle ALU/CMP unit. It adds configurable pipeline depth, valid/ready backpressure, pipeline flush, branch/jump resolution (taken flag plus target) and a saturating stall counter.

## Interface
Parameters:
- STAGES, 1, number of register stages between input acceptance and output; legal range 1..4
- STALL_W, 16, width of the stall counter

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- flush  in  1  squash every in-flight op; synchronous
- in_valid  in  1  upstream offers an op
- in_ready  out  1  unit accepts the op this cycle
- in_instr  in  ooo_instr_t  operands: rs1_data, rs2_data, pc, imm
- in_ctrl  in  ctrl_word_t  alu_op, cmp_op, alu_m1_sel, alu_m2_sel, alu_cmp_sel
- in_br_mode  in  br_mode_t  BR_NONE / BR_COND / BR_JAL / BR_JALR
- out_valid  out  1  result available
- out_ready  in  1  downstream (CDB) takes the result
- out_instr  out  ooo_instr_t  in_instr with rd_data filled
- out_br_en  out  1  control transfer taken
- out_br_target  out  32  resolved next PC
- stall_cnt  out  STALL_W  saturating count of backpressure cycles

## Operation
- Compute stage is combinational at the input. The result is captured into stage 0 on accept (in_valid && in_ready).
- ALU operand a = alu_m1_sel ? pc : rs1_data. Operand b = alu_m2_sel ? imm : rs2_data.
- Compare operands are rs1_data vs b.
- ALU ops: add, sub, sll, srl, sra, xor, or, and. Shift amount is b[4:0]. Arithmetic is modulo 2^32.
- Compare ops: beq, bne, blt, bge (signed); bltu, bgeu (unsigned). Undefined op gives 0.
- rd_data by in_br_mode:
  - BR_NONE and BR_COND: alu_cmp_sel ? {31'b0, cmp} : aluout.
  - BR_JAL and BR_JALR: pc+4.
- Branch outputs by in_br_mode:
  - BR_NONE: br_en=0, target=pc+4.
  - BR_COND: br_en=cmp, target = cmp ? pc+imm : pc+4.
  - BR_JAL: br_en=1, target=pc+imm.
  - BR_JALR: br_en=1, target=(rs1_data+imm) & ~32'h1.
- Each stage k holds valid[k] plus its payload. Stage k advances when valid[k] and (stage k+1 empty or advancing). The last stage advances when out_ready.
- in_ready = !rst && !flush && (!valid[0] || adv[0]).
- out_valid = valid[STAGES-1] && !flush. out_* are driven from the last-stage registers.
- flush: on the next edge all valid bits clear. The cycle's input is not accepted and the output is not handed off.
- stall_cnt increments each cycle with out_valid && !out_ready. It saturates at all-ones and is not cleared by flush.

## Timing
- Latency: an op accepted at edge N is out_valid after edge N+STAGES-1, i.e. it is visible STAGES cycles after in_valid is first sampled high with in_ready.
- Throughput: 1 op/cycle while out_ready=1. No bubble is inserted at any depth.
- Backpressure: a full pipeline with out_ready=0 holds every stage. in_ready falls in the same cycle, combinationally from out_ready.
- Payload stability: out_instr, out_br_en and out_br_target are stable while out_valid && !out_ready.
- Reset (async): all valid bits = 0, stall_cnt = 0, out_valid = 0, in_ready = 0 while rst is high. Payload registers need no reset; they read as 0 in simulation.
- Reset mid-operation: in-flight ops are lost with no output.
- in_ready returns to 1 the first cycle after rst deasserts.
- Simultaneous flush and out_ready: no transfer occurs.

## Structure
- rv32i_types gains `br_mode_t` (2-bit enum) and the constant `ALU_PIPE_MAX_STAGES = 4`.
- alu_op and cmp_op encodings continue to come from rv32i_types.
- Sub-module `alu_cmp_core` holds the pure combinational compute: rd_data, br_en, target. It is reused by any future second ALU port.
- This top contains only the stage registers, handshake and counter.

## Test plan
- STAGES=1, add: rs1=5, imm=7, alu_m2_sel=1, out_ready=1 -> next cycle out_valid=1, rd_data=12, br_en=0, target=pc+4.
- STAGES=3, BR_COND blt: rs1=-1, rs2=1, pc=0x100, imm=0x20 -> after 3 cycles br_en=1, target=0x120. With bltu on the same operands -> br_en=0, target=0x104.
- BR_JALR: rs1=0x1003, imm=0 -> target=0x1002, rd_data=pc+4, br_en=1.
- STAGES=2, stream 6 back-to-back ops with out_ready low for cycles 3-5:
  - in_ready drops once 2 ops are held.
  - No op is lost or duplicated; output order matches input.
  - stall_cnt=3.
- flush asserted with 3 ops in flight (STAGES=4) -> out_valid=0 next cycle. A new op issued after flush emerges 4 cycles later with correct data.
- Async rst pulse mid-stream, not clock-aligned -> out_valid=0 and stall_cnt=0 immediately. in_ready=1 on the first cycle after release.
